// File: rtl/bullet_pool.sv
// Projectile pool for one tank: launches the lowest free slot on fire and flies each
// bullet with wall bounce, lifetime expiry and kill, all advancing once per frame.

module bullet_trig (
    input  logic [6:0] angle,
    output logic [8:0] sin_sm,
    output logic [8:0] cos_sm
);
    // Quarter-wave table, 32 steps per quadrant, magnitude scaled to 255.
    function automatic logic [7:0] qsin(input logic [5:0] k);
        case (k)
            6'd0:  return 8'd0;    6'd1:  return 8'd13;   6'd2:  return 8'd25;
            6'd3:  return 8'd37;   6'd4:  return 8'd50;   6'd5:  return 8'd62;
            6'd6:  return 8'd74;   6'd7:  return 8'd86;   6'd8:  return 8'd98;
            6'd9:  return 8'd109;  6'd10: return 8'd120;  6'd11: return 8'd131;
            6'd12: return 8'd142;  6'd13: return 8'd152;  6'd14: return 8'd162;
            6'd15: return 8'd171;  6'd16: return 8'd180;  6'd17: return 8'd189;
            6'd18: return 8'd197;  6'd19: return 8'd205;  6'd20: return 8'd212;
            6'd21: return 8'd219;  6'd22: return 8'd225;  6'd23: return 8'd231;
            6'd24: return 8'd236;  6'd25: return 8'd240;  6'd26: return 8'd244;
            6'd27: return 8'd247;  6'd28: return 8'd250;  6'd29: return 8'd252;
            6'd30: return 8'd254;  6'd31: return 8'd255;
            default: return 8'd255;
        endcase
    endfunction

    function automatic logic [8:0] sin_of(input logic [6:0] a);
        logic [7:0] mag;
        mag = a[5] ? qsin(6'd32 - {1'b0, a[4:0]}) : qsin({1'b0, a[4:0]});
        return {a[6], mag};
    endfunction

    always_comb begin
        sin_sm = sin_of(angle);
        cos_sm = sin_of(angle + 7'd32);
    end
endmodule

module bullet_pool #(
    parameter int unsigned NUM_BULLETS     = 5,
    parameter int unsigned COORD_W         = 10,
    parameter int unsigned FRAC_BITS       = 4,
    parameter int unsigned SPEED_SHIFT     = 2,
    parameter int unsigned MUZZLE_DIST     = 14,
    parameter int unsigned LIFETIME_FRAMES = 240,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned PARK_X          = 0,
    parameter int unsigned PARK_Y          = 461
) (
    input  logic                           frame_clk,
    input  logic                           reset,
    input  logic                           fire,
    input  logic [6:0]                     fire_angle,
    input  logic [COORD_W-1:0]             fire_x,
    input  logic [COORD_W-1:0]             fire_y,
    input  logic [NUM_BULLETS-1:0]         xwall,
    input  logic [NUM_BULLETS-1:0]         ywall,
    input  logic [NUM_BULLETS-1:0]         kill,
    output logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
    output logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
    output logic [NUM_BULLETS-1:0]         active,
    output logic                           fire_ack,
    output logic                           pool_full
);
    localparam int unsigned POS_W  = COORD_W + FRAC_BITS;
    localparam int unsigned LIFE_W = 10;
    localparam int unsigned CD_W   = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [POS_W-1:0]  PARK_XP   = POS_W'(PARK_X << FRAC_BITS);
    localparam logic [POS_W-1:0]  PARK_YP   = POS_W'(PARK_Y << FRAC_BITS);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIFETIME_FRAMES);
    localparam logic [CD_W-1:0]   CD_INIT   = CD_W'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_FLY, S_BOUNCE} slot_state_t;

    slot_state_t       state [NUM_BULLETS];
    logic [POS_W-1:0]  pos_x [NUM_BULLETS];
    logic [POS_W-1:0]  pos_y [NUM_BULLETS];
    logic [POS_W-1:0]  vel_x [NUM_BULLETS];
    logic [POS_W-1:0]  vel_y [NUM_BULLETS];
    logic [LIFE_W-1:0] life  [NUM_BULLETS];
    logic [CD_W-1:0]   cooldown;

    logic [8:0]             sin_sm, cos_sm;
    logic [POS_W-1:0]       cos_mag, sin_mag, cos_off, sin_off;
    logic [POS_W-1:0]       base_x, base_y, spawn_x, spawn_y, spawn_vx, spawn_vy;
    logic [NUM_BULLETS-1:0] launch_sel;
    logic                   slot_free, do_launch;

    bullet_trig u_trig (
        .angle  (fire_angle),
        .sin_sm (sin_sm),
        .cos_sm (cos_sm)
    );

    // Spawn point and velocity; two's complement in POS_W bits so adds wrap naturally.
    always_comb begin
        cos_mag = POS_W'(cos_sm[7:0]);
        sin_mag = POS_W'(sin_sm[7:0]);
        cos_off = POS_W'(cos_mag * MUZZLE_DIST);
        sin_off = POS_W'(sin_mag * MUZZLE_DIST);
        base_x  = {fire_x, {FRAC_BITS{1'b0}}};
        base_y  = {fire_y, {FRAC_BITS{1'b0}}};
        spawn_x = cos_sm[8] ? base_x - cos_off : base_x + cos_off;
        spawn_y = sin_sm[8] ? base_y + sin_off : base_y - sin_off;
        if (cos_mag == '0)
            spawn_vx = '0;
        else
            spawn_vx = cos_sm[8] ? -(cos_mag << SPEED_SHIFT) : (cos_mag << SPEED_SHIFT);
        if (sin_mag == '0)
            spawn_vy = '0;
        else
            spawn_vy = sin_sm[8] ? (sin_mag << SPEED_SHIFT) : -(sin_mag << SPEED_SHIFT);
    end

    // Only slots idle at the start of the frame are candidates; retiring ones are not.
    always_comb begin
        launch_sel = '0;
        slot_free  = 1'b0;
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            if (!slot_free && state[i] == S_IDLE) begin
                launch_sel[i] = 1'b1;
                slot_free     = 1'b1;
            end
        end
        do_launch = fire && (cooldown == '0) && slot_free;
    end

    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            fire_ack <= 1'b0;
            cooldown <= '0;
            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                state[i] <= S_IDLE;
                pos_x[i] <= PARK_XP;
                pos_y[i] <= PARK_YP;
                vel_x[i] <= '0;
                vel_y[i] <= '0;
                life[i]  <= '0;
            end
        end else begin
            fire_ack <= do_launch;
            if (do_launch)
                cooldown <= CD_INIT;
            else if (cooldown != '0)
                cooldown <= cooldown - 1'b1;

            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                case (state[i])
                    S_IDLE: begin
                        if (do_launch && launch_sel[i]) begin
                            state[i] <= S_FLY;
                            pos_x[i] <= spawn_x;
                            pos_y[i] <= spawn_y;
                            vel_x[i] <= spawn_vx;
                            vel_y[i] <= spawn_vy;
                            life[i]  <= LIFE_INIT;
                        end
                    end
                    default: begin
                        if (kill[i] || life[i] == LIFE_W'(1)) begin
                            state[i] <= S_IDLE;
                            pos_x[i] <= PARK_XP;
                            pos_y[i] <= PARK_YP;
                        end else begin
                            life[i] <= life[i] - 1'b1;
                            if (state[i] == S_FLY && (xwall[i] || ywall[i])) begin
                                if (xwall[i]) vel_x[i] <= -vel_x[i];
                                if (ywall[i]) vel_y[i] <= -vel_y[i];
                                state[i] <= S_BOUNCE;
                            end else begin
                                pos_x[i] <= pos_x[i] + vel_x[i];
                                pos_y[i] <= pos_y[i] + vel_y[i];
                                state[i] <= (xwall[i] || ywall[i]) ? S_BOUNCE : S_FLY;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        bullet_x = '0;
        bullet_y = '0;
        active   = '0;
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            bullet_x[i*COORD_W +: COORD_W] = pos_x[i][POS_W-1 -: COORD_W];
            bullet_y[i*COORD_W +: COORD_W] = pos_y[i][POS_W-1 -: COORD_W];
            active[i] = (state[i] != S_IDLE);
        end
        pool_full = &active;
    end
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: launch geometry, bounce, cooldown, pool fill,
// lifetime expiry, kill and asynchronous reset.

module tb_bullet_pool;
    localparam int N  = 5;
    localparam int CW = 10;

    logic            frame_clk = 1'b0;
    logic            reset;
    logic            fire;
    logic [6:0]      fire_angle;
    logic [CW-1:0]   fire_x, fire_y;
    logic [N-1:0]    xwall, ywall, kill;
    logic [N*CW-1:0] bullet_x, bullet_y;
    logic [N-1:0]    active;
    logic            fire_ack, pool_full;

    int checks   = 0;
    int failures = 0;

    always #5 frame_clk = ~frame_clk;

    bullet_pool #(
        .NUM_BULLETS     (N),
        .COORD_W         (CW),
        .FRAC_BITS       (4),
        .SPEED_SHIFT     (2),
        .MUZZLE_DIST     (14),
        .LIFETIME_FRAMES (240),
        .COOLDOWN_FRAMES (8),
        .PARK_X          (0),
        .PARK_Y          (461)
    ) dut (
        .frame_clk  (frame_clk),
        .reset      (reset),
        .fire       (fire),
        .fire_angle (fire_angle),
        .fire_x     (fire_x),
        .fire_y     (fire_y),
        .xwall      (xwall),
        .ywall      (ywall),
        .kill       (kill),
        .bullet_x   (bullet_x),
        .bullet_y   (bullet_y),
        .active     (active),
        .fire_ack   (fire_ack),
        .pool_full  (pool_full)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bx(input int i);
        return int'(bullet_x[i*CW +: CW]);
    endfunction

    function automatic int by(input int i);
        return int'(bullet_y[i*CW +: CW]);
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic launch(input int ang, input int x, input int y);
        fire_angle = 7'(ang);
        fire_x     = CW'(x);
        fire_y     = CW'(y);
        fire       = 1'b1;
        tick();
        fire       = 1'b0;
        check("launch_ack", int'(fire_ack), 1);
        check("launch_active0", int'(active[0]), 1);
    endtask

    task automatic kill_slot(input int i);
        kill[i] = 1'b1;
        tick();
        kill = '0;
        check("kill_active", int'(active[i]), 0);
        check("kill_park_x", bx(i), 0);
        check("kill_park_y", by(i), 461);
    endtask

    int   exp_launches;
    logic exp_ack;

    initial begin
        reset = 1'b1; fire = 1'b0; fire_angle = '0; fire_x = '0; fire_y = '0;
        xwall = '0; ywall = '0; kill = '0;
        idle(2);
        check("rst_active", int'(active), 0);
        check("rst_ack", int'(fire_ack), 0);
        check("rst_full", int'(pool_full), 0);
        for (int i = 0; i < N; i++) begin
            check("rst_x", bx(i), 0);
            check("rst_y", by(i), 461);
        end
        reset = 1'b0;
        tick();

        // Angle 0: cos 255 -> spawn 1600+3570 = 5170/16, vx 1020.
        launch(0, 100, 200);
        check("a0_x0", bx(0), 323);
        check("a0_y0", by(0), 200);
        tick();
        check("a0_ack_drop", int'(fire_ack), 0);
        check("a0_x1", bx(0), 386);
        tick();
        check("a0_x2", bx(0), 450);
        check("a0_y2", by(0), 200);

        // xwall for two frames: hold on hit frame, then move back.
        xwall[0] = 1'b1;
        tick();
        check("bx_hit", bx(0), 450);
        tick();
        check("bx_bounce", bx(0), 386);
        xwall = '0;
        tick();
        check("bx_fly", bx(0), 323);
        tick();
        check("bx_fly2", bx(0), 259);
        check("bx_y", by(0), 200);
        kill_slot(0);

        // Angle 32 (up): y 6400-3570 = 2830/16, vy -1020, vx 0.
        idle(10);
        launch(32, 300, 400);
        check("a32_x0", bx(0), 300);
        check("a32_y0", by(0), 176);
        tick();
        check("a32_y1", by(0), 113);
        check("a32_x1", bx(0), 300);
        ywall[0] = 1'b1;
        tick();
        ywall = '0;
        check("by_hit", by(0), 113);
        tick();
        check("by_bounce", by(0), 176);
        kill_slot(0);

        // Angle 64 (left): sin magnitude 0 with sign set must give vy 0.
        idle(10);
        launch(64, 500, 100);
        check("a64_x0", bx(0), 276);
        check("a64_y0", by(0), 100);
        tick();
        check("a64_x1", bx(0), 213);
        check("a64_y1", by(0), 100);
        kill_slot(0);

        // Angle 16: sin=cos=180, offset 2520, v 720.
        idle(10);
        launch(16, 200, 300);
        check("a16_x0", bx(0), 357);
        check("a16_y0", by(0), 142);
        tick();
        check("a16_x1", bx(0), 402);
        check("a16_y1", by(0), 97);
        kill_slot(0);

        // Fire held: launches at frames 0, 9, 18, 27, 36.
        idle(10);
        fire_angle = '0; fire_x = 10'd100; fire_y = 10'd200;
        fire = 1'b1;
        exp_launches = 0;
        for (int t = 0; t < 60; t++) begin
            tick();
            exp_ack = (t % 9 == 0) && (t <= 36);
            if (exp_ack) exp_launches++;
            check($sformatf("hold_ack_t%0d", t), int'(fire_ack), int'(exp_ack));
            check($sformatf("hold_cnt_t%0d", t), $countones(active), exp_launches);
            check($sformatf("hold_full_t%0d", t), int'(pool_full), int'(t >= 36));
        end
        fire = 1'b0;

        // Frame 60: kill slot 2.
        kill_slot(2);
        check("kill2_others", int'(active), 5'b11011);
        check("kill2_full", int'(pool_full), 0);

        // Slot 0 launched at frame 0 expires at frame 240.
        idle(179);
        check("life_239", int'(active), 5'b11011);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check("life_240", int'(active), 5'b11110);
        check("life_240_ack", int'(fire_ack), 1);
        check("life_240_park", by(0), 461);
        idle(8);
        check("life1_248", int'(active[1]), 1);
        tick();
        check("life1_249", int'(active), 5'b11100);

        // Asynchronous reset with three slots in flight.
        #2;
        reset = 1'b1;
        #1;
        check("arst_active", int'(active), 0);
        check("arst_x4", bx(4), 0);
        check("arst_y4", by(4), 461);
        tick();
        reset = 1'b0;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check("post_rst_ack", int'(fire_ack), 1);
        check("post_rst_active", int'(active), 5'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
